// File: rtl/inst_fetch_ras.sv
// Program-counter / fetch sequencer with program-start table, stall, halt/done handshake and flag-qualified branches.
// Define FETCH_RAS_EN to add the call/return-address stack; otherwise call is a plain jump and ret a no-op.
module inst_fetch_ras #(
    parameter int PC_WIDTH   = 11,
    parameter int PROG_COUNT = 4,
    parameter int RAS_DEPTH  = 4,
    localparam int SEL_W     = (PROG_COUNT > 1) ? $clog2(PROG_COUNT) : 1,
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [SEL_W-1:0]               prog_sel,
    input  logic [PROG_COUNT*PC_WIDTH-1:0] prog_base,
    input  logic                           stall,
    input  logic                           halt,
    input  logic                           branch_abs,
    input  logic                           branch_rel,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           alu_flag,
    input  logic [PC_WIDTH-1:0]            target,
    output logic [PC_WIDTH-1:0]            pc,
    output logic                           running,
    output logic                           done,
    output logic [CNT_W-1:0]               ras_count,
    output logic                           ras_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] start_addr;
    logic [PC_WIDTH-1:0] pc_next_seq;

    // Out-of-range program indices fall back to entry 0.
    always_comb begin
        start_addr = prog_base[PC_WIDTH-1:0];
        for (int k = 1; k < PROG_COUNT; k++) begin
            if (int'(prog_sel) == k) begin
                start_addr = prog_base[k*PC_WIDTH +: PC_WIDTH];
            end
        end
    end

    assign pc_next_seq = pc + PC_WIDTH'(1);

`ifdef FETCH_RAS_EN
    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [CNT_W-1:0]    count_q;
    logic                err_q;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_full;
    logic                ras_empty;
    logic                push_ok;

    always_comb begin
        ras_top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1)) begin
                ras_top = ras_mem[i];
            end
        end
    end

    assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
    assign ras_empty = (count_q == '0);
    // Must mirror the priority chain of the main sequencer so a push happens only when call is the winning action.
    assign push_ok   = !reset && !start && (state == RUN) && !stall && !halt && !ret && call && !ras_full;

    always_ff @(posedge clk) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (push_ok && (count_q == CNT_W'(i))) begin
                ras_mem[i] <= pc_next_seq;
            end
        end
    end

    assign ras_count = count_q;
    assign ras_err   = err_q;
`else
    assign ras_count = '0;
    assign ras_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef FETCH_RAS_EN
            count_q <= '0;
            err_q   <= 1'b0;
`endif
        end else if (start) begin
            state   <= RUN;
            pc      <= start_addr;
            running <= 1'b1;
            done    <= 1'b0;
`ifdef FETCH_RAS_EN
            count_q <= '0;
            err_q   <= 1'b0;
`endif
        end else if (state == RUN && !stall) begin
            if (halt) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
            end else if (ret) begin
`ifdef FETCH_RAS_EN
                if (!ras_empty) begin
                    pc      <= ras_top;
                    count_q <= count_q - CNT_W'(1);
                end else begin
                    pc    <= pc_next_seq;
                    err_q <= 1'b1;
                end
`else
                pc <= pc_next_seq;
`endif
            end else if (call) begin
                pc <= target;
`ifdef FETCH_RAS_EN
                if (ras_full) begin
                    err_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
`endif
            end else if (branch_abs && alu_flag) begin
                pc <= target;
            end else if (branch_rel && alu_flag) begin
                // Equal widths make the modular add identical to a sign-extended one.
                pc <= pc + target;
            end else begin
                pc <= pc_next_seq;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ras.sv
// Directed self-checking bench for inst_fetch_ras; expectations adapt to whether FETCH_RAS_EN is defined.
module tb_inst_fetch_ras;

    localparam int PC_WIDTH   = 11;
    localparam int PROG_COUNT = 3;
    localparam int RAS_DEPTH  = 4;

    logic                           clk;
    logic                           reset;
    logic                           start;
    logic [1:0]                     prog_sel;
    logic [PROG_COUNT*PC_WIDTH-1:0] prog_base;
    logic                           stall;
    logic                           halt;
    logic                           branch_abs;
    logic                           branch_rel;
    logic                           call;
    logic                           ret;
    logic                           alu_flag;
    logic [PC_WIDTH-1:0]            target;
    logic [PC_WIDTH-1:0]            pc;
    logic                           running;
    logic                           done;
    logic [2:0]                     ras_count;
    logic                           ras_err;

    int total = 0;
    int bad   = 0;

    inst_fetch_ras #(
        .PC_WIDTH  (PC_WIDTH),
        .PROG_COUNT(PROG_COUNT),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_sel  (prog_sel),
        .prog_base (prog_base),
        .stall     (stall),
        .halt      (halt),
        .branch_abs(branch_abs),
        .branch_rel(branch_rel),
        .call      (call),
        .ret       (ret),
        .alu_flag  (alu_flag),
        .target    (target),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .ras_count (ras_count),
        .ras_err   (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge and outputs are sampled at that same point.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearControls();
        start      = 1'b0;
        stall      = 1'b0;
        halt       = 1'b0;
        branch_abs = 1'b0;
        branch_rel = 1'b0;
        call       = 1'b0;
        ret        = 1'b0;
        alu_flag   = 1'b0;
        target     = '0;
    endtask

    initial begin
        prog_base = {11'h040, 11'h050, 11'h07D};
        prog_sel  = 2'd0;
        clearControls();

        reset = 1'b1;
        applyStimulus(2);
        reset = 1'b0;
        checkOutput("reset_pc", 32'(pc), 32'h000);
        checkOutput("reset_running", 32'(running), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_count", 32'(ras_count), 0);
        checkOutput("reset_err", 32'(ras_err), 0);

        branch_abs = 1'b1; alu_flag = 1'b1; target = 11'h123;
        applyStimulus(1);
        checkOutput("idle_ignores_branch", 32'(pc), 32'h000);
        checkOutput("idle_not_running", 32'(running), 0);
        clearControls();

        start = 1'b1; prog_sel = 2'd2;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("start_pc", 32'(pc), 32'h040);
        checkOutput("start_running", 32'(running), 1);
        applyStimulus(3);
        checkOutput("increment_x3", 32'(pc), 32'h043);

        start = 1'b1; prog_sel = 2'd1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("start_sel1", 32'(pc), 32'h050);
        branch_rel = 1'b1; alu_flag = 1'b1; target = 11'h7FE;
        applyStimulus(1);
        checkOutput("branch_rel_taken", 32'(pc), 32'h04E);
        clearControls();

        start = 1'b1; prog_sel = 2'd1;
        applyStimulus(1);
        start = 1'b0;
        branch_rel = 1'b1; alu_flag = 1'b0; target = 11'h7FE;
        applyStimulus(1);
        checkOutput("branch_rel_not_taken", 32'(pc), 32'h051);
        clearControls();

        stall = 1'b1; branch_abs = 1'b1; alu_flag = 1'b1; target = 11'h3AA;
        applyStimulus(1);
        checkOutput("stall_cycle1", 32'(pc), 32'h051);
        applyStimulus(1);
        checkOutput("stall_cycle2", 32'(pc), 32'h051);
        stall = 1'b0; target = 11'h07F;
        applyStimulus(1);
        checkOutput("branch_abs_taken", 32'(pc), 32'h07F);
        clearControls();

        halt = 1'b1;
        applyStimulus(1);
        halt = 1'b0;
        checkOutput("halt_done", 32'(done), 1);
        checkOutput("halt_running", 32'(running), 0);
        checkOutput("halt_pc_held", 32'(pc), 32'h07F);
        call = 1'b1; target = 11'h300;
        applyStimulus(1);
        clearControls();
        checkOutput("done_ignores_call", 32'(pc), 32'h07F);
        checkOutput("done_sticky", 32'(done), 1);

        start = 1'b1; prog_sel = 2'd0;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("restart_pc", 32'(pc), 32'h07D);
        checkOutput("restart_done_low", 32'(done), 0);

        start = 1'b1; halt = 1'b1; prog_sel = 2'd2;
        applyStimulus(1);
        clearControls();
        checkOutput("start_beats_halt_pc", 32'(pc), 32'h040);
        checkOutput("start_beats_halt_running", 32'(running), 1);

        branch_abs = 1'b1; alu_flag = 1'b1; target = 11'h7FE;
        applyStimulus(1);
        clearControls();
        applyStimulus(1);
        checkOutput("pc_top", 32'(pc), 32'h7FF);
        applyStimulus(1);
        checkOutput("pc_wrap", 32'(pc), 32'h000);

        call = 1'b1; target = 11'h100;
        applyStimulus(1);
        clearControls();
        checkOutput("call_pc", 32'(pc), 32'h100);
`ifdef FETCH_RAS_EN
        checkOutput("call_count", 32'(ras_count), 1);
        ret = 1'b1;
        applyStimulus(1);
        clearControls();
        checkOutput("ret_pc", 32'(pc), 32'h001);
        checkOutput("ret_count", 32'(ras_count), 0);

        branch_abs = 1'b1; alu_flag = 1'b1; target = 11'h020;
        applyStimulus(1);
        clearControls();
        ret = 1'b1;
        applyStimulus(1);
        clearControls();
        checkOutput("ret_empty_pc", 32'(pc), 32'h021);
        checkOutput("ret_empty_err", 32'(ras_err), 1);
        start = 1'b1; prog_sel = 2'd1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("start_clears_err", 32'(ras_err), 0);

        branch_abs = 1'b1; alu_flag = 1'b1; target = 11'h010;
        applyStimulus(1);
        clearControls();
        call = 1'b1; target = 11'h100;
        applyStimulus(1);
        clearControls();
        ret = 1'b1;
        applyStimulus(1);
        clearControls();
        checkOutput("call_ret_pc", 32'(pc), 32'h011);

        for (int i = 0; i < 5; i++) begin
            call = 1'b1; target = 11'h200 + 11'(i);
            applyStimulus(1);
            if (i == 3) begin
                checkOutput("fourth_call_count", 32'(ras_count), 4);
                checkOutput("fourth_call_err", 32'(ras_err), 0);
            end
        end
        clearControls();
        checkOutput("overflow_pc", 32'(pc), 32'h204);
        checkOutput("overflow_count", 32'(ras_count), 4);
        checkOutput("overflow_err", 32'(ras_err), 1);

        call = 1'b1; ret = 1'b1; target = 11'h555;
        applyStimulus(1);
        clearControls();
        checkOutput("call_ret_same_pc", 32'(pc), 32'h203);
        checkOutput("call_ret_same_count", 32'(ras_count), 3);
        stall = 1'b1; ret = 1'b1;
        applyStimulus(1);
        checkOutput("stall_ret_pc", 32'(pc), 32'h203);
        checkOutput("stall_ret_count", 32'(ras_count), 3);
        stall = 1'b0;
        applyStimulus(1);
        clearControls();
        checkOutput("pop_pc", 32'(pc), 32'h202);
        checkOutput("pop_count", 32'(ras_count), 2);
`else
        checkOutput("call_no_push", 32'(ras_count), 0);
        ret = 1'b1;
        applyStimulus(1);
        clearControls();
        checkOutput("ret_noop_pc", 32'(pc), 32'h101);
        checkOutput("ret_noop_err", 32'(ras_err), 0);
        call = 1'b1; ret = 1'b1; target = 11'h555;
        applyStimulus(1);
        clearControls();
        checkOutput("call_ret_same_pc", 32'(pc), 32'h102);
`endif

        start = 1'b1; prog_sel = 2'd3;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("sel_out_of_range", 32'(pc), 32'h07D);
        applyStimulus(2);
        checkOutput("pre_reset_pc", 32'(pc), 32'h07F);

        reset = 1'b1; call = 1'b1; target = 11'h444;
        applyStimulus(1);
        reset = 1'b0;
        clearControls();
        checkOutput("midrun_reset_pc", 32'(pc), 32'h000);
        checkOutput("midrun_reset_running", 32'(running), 0);
        checkOutput("midrun_reset_done", 32'(done), 0);
        checkOutput("midrun_reset_count", 32'(ras_count), 0);
        checkOutput("midrun_reset_err", 32'(ras_err), 0);
        applyStimulus(2);
        checkOutput("idle_after_reset", 32'(pc), 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ras.md
# inst_fetch_ras

Parametrised program-counter / fetch sequencer for the 141L core, successor to the single-program PC block. Adds a selectable program-start table, pipeline stall, halt/done handshake with the test bench, flag-qualified branches and an optional call/return-address stack. Sits between the test bench/control decoder and instruction ROM; `pc` drives the ROM address directly.

## Interface
- `PC_WIDTH`, 11, PC and target width in bits (2..32).
- `PROG_COUNT`, 4, number of programs in the start table (>=1).
- `RAS_DEPTH`, 4, return-address stack entries (>=1; used only with `FETCH_RAS_EN`).

- `clk`  in  1  rising-edge clock; all state changes on posedge only.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  test bench request: begin program `prog_sel`.
- `prog_sel`  in  max(1,$clog2(PROG_COUNT))  program index; values >= PROG_COUNT select entry 0.
- `prog_base`  in  PROG_COUNT*PC_WIDTH  start-address table; entry k at bits [k*PC_WIDTH +: PC_WIDTH].
- `stall`  in  1  hold PC and stack this cycle.
- `halt`  in  1  current instruction is HALT.
- `branch_abs`  in  1  jump to `target` if `alu_flag`.
- `branch_rel`  in  1  jump to `pc + target` (signed) if `alu_flag`.
- `call`  in  1  unconditional jump to `target`, push `pc+1`.
- `ret`  in  1  unconditional return to popped address.
- `alu_flag`  in  1  branch condition from ALU.
- `target`  in  PC_WIDTH  branch/call target or two's-complement offset.
- `pc`  out  PC_WIDTH  program counter register.
- `running`  out  1  state == RUN.
- `done`  out  1  state == DONE (program finished).
- `ras_count`  out  $clog2(RAS_DEPTH+1)  stack occupancy.
- `ras_err`  out  1  sticky: push when full or pop when empty.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE, `pc`=0, `ras_count`=0, `ras_err`=0, `running`=0, `done`=0.
- `start` (any state, ignores `stall`): `pc`<=prog_base[prog_sel], state<=RUN, stack emptied, `ras_err` cleared.
- IDLE/DONE without `start`: all registers hold; all other inputs ignored.
- RUN, priority high->low: `stall` (hold all) > `halt` (state<=DONE, `pc` holds) > `ret` > `call` > `branch_abs` > `branch_rel` > increment.
- `ret`: non-empty -> `pc`<=top, pop. Empty -> `pc`<=pc+1, `ras_err`<=1.
- `call`: `pc`<=target; not full -> push pc+1; full -> no push, `ras_err`<=1.
- `branch_abs`/`branch_rel` with `alu_flag`=0: fall through to increment.
- `branch_rel`: `pc`<=pc + target, target sign-extended, result mod 2^PC_WIDTH.
- Increment wraps 2^PC_WIDTH-1 -> 0 with no flag.
- Simultaneous `call`+`ret`: ret only; stack changes by exactly one pop.

## Timing
- All outputs registered; zero combinational paths input->output.
- Every control input sampled at posedge; effect visible on `pc` one cycle later.
- `done` rises the cycle after `halt` accepted; stays until `start` or `reset`.
- `start` and `halt` same cycle: `start` wins.
- `reset` mid-program overrides everything, same-edge.
- Push/pop and `ras_count` update on the same edge as `pc`.

## Configuration
- `FETCH_RAS_EN` defined: stack of RAS_DEPTH entries as above.
- Not defined: no stack storage; `call` behaves as unconditional absolute jump (no push), `ret` as `pc+1` no-op; `ras_count` and `ras_err` tied 0.

## Test plan
- Reset, then `start`, prog_sel=2, prog_base[2]=0x040 -> `pc`=0x040, `running`=1 next cycle; 3 idle cycles -> 0x043.
- pc=0x050, `branch_rel` target=0x7FE (-2), alu_flag=1 -> 0x04E; alu_flag=0 -> 0x051; `stall` held 2 cycles -> pc unchanged.
- (RAS_EN, depth 4) pc=0x010 `call` 0x100 -> pc=0x100, ras_count=1; `ret` -> 0x011, count=0; 5 nested calls -> 5th jumps, count=4, ras_err=1.
- `ret` on empty stack at pc=0x020 -> 0x021, ras_err=1; next `start` clears ras_err.
- `halt` at pc=0x07F -> done=1, running=0, pc=0x07F held; `start` prog_sel=0 -> done=0, pc=prog_base[0].
- pc=0x7FF increment -> 0x000; `reset` asserted mid-RUN -> pc=0, IDLE, all flags 0 next cycle.
